branch_history_table: RTL and testbench

- Parametrised branch history table (BHT) of N-bit 2^INDEX_BITS-entry prediction counters, indexed by PC.
- Sits in the fetch stage: fetch issues a registered lookup; execute/resolve writes back the actual outcome.
- Generalises the single 2-bit predictor FSM to any table depth and counter width.
- Provides two update policies (plain saturating, or strong/weak hysteresis) and a saturating mispredict counter.

---
 rtl/branch_history_table.sv | 148 ++++++++++++++
 tb/tb_branch_history_table.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// PC-indexed table of saturating/hysteresis prediction counters with a mispredict counter.
// Latency: lookup result registered one cycle after pred_valid; update takes effect at the same edge.
// Backpressure: none; lookups and updates are accepted every cycle, and same-index pairs bypass write-first.
module branch_history_table #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int PC_LSB     = 2,
    parameter int MODE       = 0,
    parameter int PERF_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic [31:0]          pred_pc,
    output logic                 pred_out_valid,
    output logic                 pred_taken,
    output logic [CTR_BITS-1:0]  pred_ctr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    output logic                 upd_mispredict,
    output logic [PERF_BITS-1:0] mispred_count
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int MSB   = CTR_BITS - 1;

    // Counter landmarks: strong not-taken, weak not-taken, weak taken, strong taken.
    localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [CTR_BITS-1:0] CTR_WNT  = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MID  = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    localparam logic [PERF_BITS-1:0] PERF_ONE = {{(PERF_BITS-1){1'b0}}, 1'b1};
    localparam logic [PERF_BITS-1:0] PERF_MAX = '1;

    // Counter storage and registered outputs.
    logic [CTR_BITS-1:0]  tbl_q [DEPTH];
    logic                 pred_out_valid_q, pred_out_valid_d;
    logic [CTR_BITS-1:0]  pred_ctr_q, pred_ctr_d;
    logic                 upd_mispredict_q, upd_mispredict_d;
    logic [PERF_BITS-1:0] mispred_count_q, mispred_count_d;

    // Update-side datapath.
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]   upd_cur;
    logic [CTR_BITS-1:0]   upd_new;
    logic                  upd_mis;

    // Lookup-side datapath.
    logic [INDEX_BITS-1:0] pred_idx;
    logic                  bypass_hit;
    logic [CTR_BITS-1:0]   lookup_ctr;

    // Only the index field of each PC matters; everything else is deliberately dropped (aliasing allowed).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, upd_pc};

    // Next counter value for a resolved branch, according to the selected policy.
    function automatic logic [CTR_BITS-1:0] next_ctr(input logic [CTR_BITS-1:0] c,
                                                     input logic                taken);
        logic [CTR_BITS-1:0] n;
        logic                mis;
        n   = c;
        mis = c[MSB] ^ taken;
        if (MODE == 0) begin
            // Plain saturating up/down counter.
            if (taken) begin
                n = (c == CTR_MAX) ? CTR_MAX : c + CTR_ONE;
            end else begin
                n = (c == CTR_ZERO) ? CTR_ZERO : c - CTR_ONE;
            end
        end else begin
            // Hysteresis: correct predictions snap to strong, a miss from strong
            // only weakens, a miss from a weak/intermediate state flips to strong.
            if (!mis) begin
                n = c[MSB] ? CTR_MAX : CTR_ZERO;
            end else if (c == CTR_MAX) begin
                n = CTR_MID;
            end else if (c == CTR_ZERO) begin
                n = CTR_WNT;
            end else begin
                n = taken ? CTR_MAX : CTR_ZERO;
            end
        end
        return n;
    endfunction

    // Read the entry being resolved, detect a mispredict and compute its new value.
    always_comb begin
        upd_idx = upd_pc[PC_LSB+INDEX_BITS-1:PC_LSB];
        upd_cur = tbl_q[upd_idx];
        upd_mis = upd_cur[MSB] ^ upd_taken;
        upd_new = next_ctr(upd_cur, upd_taken);
    end

    // Read the looked-up entry; a same-cycle update to that index is forwarded write-first.
    always_comb begin
        pred_idx   = pred_pc[PC_LSB+INDEX_BITS-1:PC_LSB];
        bypass_hit = upd_valid && (upd_idx == pred_idx);
        lookup_ctr = bypass_hit ? upd_new : tbl_q[pred_idx];
    end

    // Next state of the output registers and the saturating mispredict counter.
    always_comb begin
        pred_out_valid_d = pred_valid;
        pred_ctr_d       = pred_valid ? lookup_ctr : pred_ctr_q;
        upd_mispredict_d = upd_valid && upd_mis;
        mispred_count_d  = mispred_count_q;
        if (upd_valid && upd_mis && (mispred_count_q != PERF_MAX)) begin
            mispred_count_d = mispred_count_q + PERF_ONE;
        end
    end

    // Output and perf registers; reset wins over any lookup/update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_out_valid_q <= 1'b0;
            pred_ctr_q       <= CTR_ZERO;
            upd_mispredict_q <= 1'b0;
            mispred_count_q  <= '0;
        end else begin
            pred_out_valid_q <= pred_out_valid_d;
            pred_ctr_q       <= pred_ctr_d;
            upd_mispredict_q <= upd_mispredict_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    // Table write: reset every entry to weakly not-taken, otherwise write the resolved entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= CTR_WNT;
            end
        end else if (upd_valid) begin
            tbl_q[upd_idx] <= upd_new;
        end
    end

    assign pred_out_valid = pred_out_valid_q;
    assign pred_ctr       = pred_ctr_q;
    assign pred_taken     = pred_ctr_q[MSB];
    assign upd_mispredict = upd_mispredict_q;
    assign mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: three instances (saturating, hysteresis, 4-bit perf counter)
// share one stimulus stream; each scenario task checks the instance it targets.
// Outputs are sampled 1 time unit after the rising edge that produced them.
module tb_branch_history_table;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    // MODE 0 instance
    logic        pov0, pt0, um0;
    logic [1:0]  pc0;
    logic [15:0] mc0;
    // MODE 1 instance
    logic        pov1, pt1, um1;
    logic [1:0]  pc1;
    logic [15:0] mc1;
    // MODE 1, PERF_BITS=4 instance
    logic        pov2, pt2, um2;
    logic [1:0]  pc2;
    logic [3:0]  mc2;

    int n_cmp;
    int n_fail;

    branch_history_table #(.MODE(0)) dut_m0 (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pov0), .pred_taken(pt0), .pred_ctr(pc0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(um0), .mispred_count(mc0)
    );

    branch_history_table #(.MODE(1)) dut_m1 (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pov1), .pred_taken(pt1), .pred_ctr(pc1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(um1), .mispred_count(mc1)
    );

    branch_history_table #(.MODE(1), .PERF_BITS(4)) dut_p4 (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pov2), .pred_taken(pt2), .pred_ctr(pc2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(um2), .mispred_count(mc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0;
        pred_pc    = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0000_0000;
        pcs[1] = 32'h0000_00FC;
        pcs[2] = 32'h0000_0100;
        apply_reset();
        n_cmp++;
        if ({pov0, pt0, pc0, um0} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pov=%0b pt=%0b ctr=%0d um=%0b expected all 0", pov0, pt0, pc0, um0);
        end
        n_cmp++;
        if (mc0 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", mc0);
        end
        for (int i = 0; i < 3; i++) begin
            pred_valid = 1'b1;
            pred_pc    = pcs[i];
            step();
            n_cmp++;
            if ({pov0, pt0, pc0} !== {1'b1, 1'b0, 2'd1}) begin
                n_fail++;
                $display("FAIL reset_lookup[%0h]: got pov=%0b pt=%0b ctr=%0d expected pov=1 pt=0 ctr=1",
                         pcs[i], pov0, pt0, pc0);
            end
        end
        pred_valid = 1'b0;
        step();
        n_cmp++;
        if ({pov0, pc0} !== {1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL idle_hold: got pov=%0b ctr=%0d expected pov=0 ctr=1", pov0, pc0);
        end
    endtask

    task automatic test_mode0_saturate();
        logic       tk  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] ec  [7] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        logic       em  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            upd_valid = 1'b1;
            upd_pc    = 32'h40;
            upd_taken = tk[i];
            step();
            n_cmp++;
            if (um0 !== em[i]) begin
                n_fail++;
                $display("FAIL m0_mispredict[%0d]: got %0b expected %0b", i, um0, em[i]);
            end
            upd_valid  = 1'b0;
            pred_valid = 1'b1;
            pred_pc    = 32'h40;
            step();
            pred_valid = 1'b0;
            n_cmp++;
            if ({pc0, pt0, um0} !== {ec[i], ec[i][1], 1'b0}) begin
                n_fail++;
                $display("FAIL m0_ctr[%0d]: got ctr=%0d pt=%0b um=%0b expected ctr=%0d pt=%0b um=0",
                         i, pc0, pt0, um0, ec[i], ec[i][1]);
            end
            if (i == 3) begin
                n_cmp++;
                if (mc0 !== 16'd1) begin
                    n_fail++;
                    $display("FAIL m0_count_up: got %0d expected 1", mc0);
                end
            end
        end
        n_cmp++;
        if (mc0 !== 16'd3) begin
            n_fail++;
            $display("FAIL m0_count_down: got %0d expected 3", mc0);
        end
    endtask

    task automatic test_mode1_hysteresis();
        logic       tk [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] ec [4] = '{2'd3, 2'd2, 2'd0, 2'd0};
        logic       em [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_pc    = 32'h40;
            upd_taken = tk[i];
            step();
            n_cmp++;
            if (um1 !== em[i]) begin
                n_fail++;
                $display("FAIL m1_mispredict[%0d]: got %0b expected %0b", i, um1, em[i]);
            end
            upd_valid  = 1'b0;
            pred_valid = 1'b1;
            pred_pc    = 32'h40;
            step();
            pred_valid = 1'b0;
            n_cmp++;
            if (pc1 !== ec[i]) begin
                n_fail++;
                $display("FAIL m1_ctr[%0d]: got %0d expected %0d", i, pc1, ec[i]);
            end
        end
        n_cmp++;
        if (mc1 !== 16'd3) begin
            n_fail++;
            $display("FAIL m1_count: got %0d expected 3", mc1);
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        pred_valid = 1'b1;
        pred_pc    = 32'h80;
        upd_valid  = 1'b1;
        upd_pc     = 32'h80;
        upd_taken  = 1'b1;
        step();
        idle_inputs();
        n_cmp++;
        if ({pov0, pc0, pt0, um0} !== {1'b1, 2'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass_same_m0: got pov=%0b ctr=%0d pt=%0b um=%0b expected 1/2/1/1", pov0, pc0, pt0, um0);
        end
        n_cmp++;
        if ({pc1, pt1} !== {2'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass_same_m1: got ctr=%0d pt=%0b expected ctr=3 pt=1", pc1, pt1);
        end
        apply_reset();
        pred_valid = 1'b1;
        pred_pc    = 32'h84;
        upd_valid  = 1'b1;
        upd_pc     = 32'h80;
        upd_taken  = 1'b1;
        step();
        idle_inputs();
        n_cmp++;
        if ({pov0, pc0, pt0} !== {1'b1, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL bypass_diff: got pov=%0b ctr=%0d pt=%0b expected 1/1/0", pov0, pc0, pt0);
        end
        // The independent update at 0x80 must still have landed.
        pred_valid = 1'b1;
        pred_pc    = 32'h80;
        step();
        pred_valid = 1'b0;
        n_cmp++;
        if (pc0 !== 2'd2) begin
            n_fail++;
            $display("FAIL bypass_diff_upd: got %0d expected 2", pc0);
        end
    endtask

    task automatic test_perf_saturate();
        // Hysteresis walk 1->3->2->0->1 mispredicts on every step with outcomes T,N,N,T.
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   exp_cnt;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            upd_valid = 1'b1;
            upd_pc    = 32'h40;
            upd_taken = pat[i % 4];
            step();
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
            n_cmp++;
            if ({um2, mc2} !== {1'b1, 4'(exp_cnt)}) begin
                n_fail++;
                $display("FAIL perf_sat[%0d]: got um=%0b count=%0d expected um=1 count=%0d", i, um2, mc2, exp_cnt);
            end
        end
        upd_valid = 1'b0;
        step();
        n_cmp++;
        if ({um2, mc2} !== {1'b0, 4'd15}) begin
            n_fail++;
            $display("FAIL perf_hold: got um=%0b count=%0d expected um=0 count=15", um2, mc2);
        end
        n_cmp++;
        if (mc1 !== 16'd20) begin
            n_fail++;
            $display("FAIL perf_wide: got %0d expected 20", mc1);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            upd_valid = 1'b1;
            upd_pc    = 32'h40;
            upd_taken = 1'b1;
            step();
        end
        upd_valid  = 1'b0;
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        step();
        n_cmp++;
        if ({pov0, pc0, mc0} !== {1'b1, 2'd3, 16'd1}) begin
            n_fail++;
            $display("FAIL midrst_trained: got pov=%0b ctr=%0d count=%0d expected 1/3/1", pov0, pc0, mc0);
        end
        // Reset collides with a lookup and a mispredicting update in the same cycle.
        rst       = 1'b1;
        upd_valid = 1'b1;
        upd_pc    = 32'h40;
        upd_taken = 1'b0;
        step();
        rst = 1'b0;
        idle_inputs();
        n_cmp++;
        if ({pov0, pc0, um0} !== {1'b0, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_drop: got pov=%0b ctr=%0d um=%0b expected 0/0/0", pov0, pc0, um0);
        end
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        step();
        pred_valid = 1'b0;
        n_cmp++;
        if ({pov0, pc0, mc0} !== {1'b1, 2'd1, 16'd0}) begin
            n_fail++;
            $display("FAIL midrst_after: got pov=%0b ctr=%0d count=%0d expected 1/1/0", pov0, pc0, mc0);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_mode0_saturate();
        test_mode1_hysteresis();
        test_bypass();
        test_perf_saturate();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
